// File: rtl/glitch_trigger_wb_pkg.sv
// Shared constants for the glitch trigger unit: register map, command bits,
// edge-select encodings and FSM state codes.
package glitch_trigger_wb_pkg;

  // Register addresses (word address, bus bits 5:2)
  localparam logic [3:0] TRIG_CTRL     = 4'h8;
  localparam logic [3:0] TRIG_CFG      = 4'h9;
  localparam logic [3:0] TRIG_COUNT_0  = 4'hA;
  localparam logic [3:0] TRIG_COUNT_1  = 4'hB;
  localparam logic [3:0] TRIG_FIRE_CNT = 4'hC;

  // TRIG_CTRL write command bits
  localparam int CTRL_ARM   = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CLR   = 2;

  // TRIG_CFG EDGE field encodings
  localparam logic [1:0] EDGE_RISE  = 2'b00;
  localparam logic [1:0] EDGE_FALL  = 2'b01;
  localparam logic [1:0] EDGE_BOTH  = 2'b10;
  localparam logic [1:0] EDGE_LEVEL = 2'b11;

  // FSM state codes
  localparam logic [1:0] T_IDLE  = 2'd0;
  localparam logic [1:0] T_ARMED = 2'd1;
  localparam logic [1:0] T_FIRE  = 2'd2;

  // Target edge count for a run: level mode completes on the first event,
  // and N=0 would otherwise never match, so both collapse to 1.
  function automatic logic [15:0] shadow_count(input logic [15:0] n,
                                               input logic [1:0]  edge_mode);
    if (edge_mode == EDGE_LEVEL || n == 16'd0)
      return 16'd1;
    return n;
  endfunction

endpackage

// File: rtl/glitch_trigger_wb_if.sv
// Wishbone slave bus bundle for the trigger unit (8-bit data, word address).
interface glitch_trigger_wb_if;
  logic [7:0] dat_i;
  logic [3:0] adr_i;
  logic [7:0] dat_o;
  logic       stb_i;
  logic       we_i;
  logic       ack_o;

  modport slave  (input dat_i, adr_i, stb_i, we_i, output dat_o, ack_o);
  modport master (output dat_i, adr_i, stb_i, we_i, input dat_o, ack_o);
endinterface

// File: rtl/glitch_trigger_wb_trig_sync_edge.sv
// Synchroniser for the asynchronous trigger pin, a one-cycle history flop,
// and the edge-select mux that produces the qualifying event strobe.
module trig_sync_edge
  import glitch_trigger_wb_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       trig_in,
  input  logic [1:0] edge_sel,
  output logic       level,
  output logic       trig_event
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  // Shift the pin through the synchroniser chain and keep last cycle's level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], trig_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];

  // Pick which transition (or level) counts as an event
  always_comb begin
    trig_event = 1'b0;
    case (edge_sel)
      EDGE_RISE:  trig_event = level & ~prev_reg;
      EDGE_FALL:  trig_event = ~level & prev_reg;
      EDGE_BOTH:  trig_event = level ^ prev_reg;
      default:    trig_event = level;
    endcase
  end

endmodule

// File: rtl/glitch_trigger_wb.sv
// Wishbone-mapped trigger unit: counts qualified edges on trig_in and issues
// a one-cycle glitch_start pulse to the glitcher once the count is reached.
module glitch_trigger_wb
  import glitch_trigger_wb_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  glitch_trigger_wb_if.slave   wb,
  input  logic                 trig_in,
  input  logic                 glitch_rdy,
  output logic                 glitch_start,
  output logic                 armed
);

  logic [1:0]  state_reg;
  logic [2:0]  cfg_reg;
  logic [15:0] count_reg;
  logic [15:0] shadow_reg;
  logic [15:0] cnt_reg;
  logic [1:0]  edge_reg;
  logic        missed_reg;
  logic        fired_reg;
  logic [7:0]  fire_cnt_reg;
  logic        ack_reg;
  logic [7:0]  dat_reg;
  logic [7:0]  rd_data;
  logic        level;
  logic        trig_event;
  logic        wb_access;
  logic        wb_wr;
  logic        arm_cmd;
  logic        abort_cmd;
  logic        clr_cmd;
  logic        fire_clr;

  trig_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .trig_in    (trig_in),
    .edge_sel   (edge_reg),
    .level      (level),
    .trig_event (trig_event)
  );

  assign wb_access = wb.stb_i & ~ack_reg;
  assign wb_wr     = wb_access & wb.we_i;
  assign arm_cmd   = wb_wr && wb.adr_i == TRIG_CTRL && wb.dat_i[CTRL_ARM];
  assign abort_cmd = wb_wr && wb.adr_i == TRIG_CTRL && wb.dat_i[CTRL_ABORT];
  assign clr_cmd   = wb_wr && wb.adr_i == TRIG_CTRL && wb.dat_i[CTRL_CLR];
  assign fire_clr  = wb_wr && wb.adr_i == TRIG_FIRE_CNT;

  assign glitch_start = (state_reg == T_FIRE);
  assign armed        = (state_reg != T_IDLE);
  assign wb.ack_o     = ack_reg;
  assign wb.dat_o     = dat_reg;

  // Read mux; unmapped addresses read zero
  always_comb begin
    rd_data = 8'h00;
    case (wb.adr_i)
      TRIG_CTRL:     rd_data = {4'b0, level, fired_reg, missed_reg, armed};
      TRIG_CFG:      rd_data = {5'b0, cfg_reg};
      TRIG_COUNT_0:  rd_data = count_reg[7:0];
      TRIG_COUNT_1:  rd_data = count_reg[15:8];
      TRIG_FIRE_CNT: rd_data = fire_cnt_reg;
      default:       rd_data = 8'h00;
    endcase
  end

  // Single-cycle registered ack with read data captured on the same edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_reg <= 1'b0;
      dat_reg <= 8'h00;
    end else begin
      ack_reg <= wb.stb_i & ~ack_reg;
      if (wb_access)
        dat_reg <= rd_data;
    end
  end

  // Configuration registers; only the next ARM picks up changes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_reg   <= 3'b000;
      count_reg <= 16'h0000;
    end else if (wb_wr) begin
      case (wb.adr_i)
        TRIG_CFG:     cfg_reg          <= wb.dat_i[2:0];
        TRIG_COUNT_0: count_reg[7:0]   <= wb.dat_i;
        TRIG_COUNT_1: count_reg[15:8]  <= wb.dat_i;
        default:      ;
      endcase
    end
  end

  // Trigger FSM; later assignments give ARM, CLR and then ABORT priority
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= T_IDLE;
      shadow_reg   <= 16'h0000;
      cnt_reg      <= 16'h0000;
      edge_reg     <= EDGE_RISE;
      missed_reg   <= 1'b0;
      fired_reg    <= 1'b0;
      fire_cnt_reg <= 8'h00;
    end else begin
      case (state_reg)
        T_ARMED: begin
          if (cnt_reg == shadow_reg) begin
            if (glitch_rdy) begin
              state_reg <= T_FIRE;
            end else begin
              missed_reg <= 1'b1;
              if (cfg_reg[2]) begin
                cnt_reg    <= 16'h0000;
                shadow_reg <= shadow_count(count_reg, cfg_reg[1:0]);
                edge_reg   <= cfg_reg[1:0];
              end else begin
                state_reg <= T_IDLE;
              end
            end
          end else if (trig_event) begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        T_FIRE: begin
          fired_reg <= 1'b1;
          if (fire_cnt_reg != 8'hFF)
            fire_cnt_reg <= fire_cnt_reg + 8'd1;
          if (cfg_reg[2]) begin
            state_reg  <= T_ARMED;
            cnt_reg    <= 16'h0000;
            shadow_reg <= shadow_count(count_reg, cfg_reg[1:0]);
            edge_reg   <= cfg_reg[1:0];
          end else begin
            state_reg <= T_IDLE;
          end
        end
        T_IDLE: ;
        default: state_reg <= T_IDLE;
      endcase

      if (arm_cmd) begin
        state_reg  <= T_ARMED;
        cnt_reg    <= 16'h0000;
        shadow_reg <= shadow_count(count_reg, cfg_reg[1:0]);
        edge_reg   <= cfg_reg[1:0];
        missed_reg <= 1'b0;
        fired_reg  <= 1'b0;
      end
      if (clr_cmd) begin
        missed_reg <= 1'b0;
        fired_reg  <= 1'b0;
      end
      if (abort_cmd)
        state_reg <= T_IDLE;
      if (fire_clr)
        fire_cnt_reg <= 8'h00;
    end
  end

endmodule

// File: doc/glitch_trigger_wb.md
Name: glitch_trigger_wb

Overview:
- Wishbone-mapped hardware trigger unit that sits directly upstream of glitch_wb.
- Watches an external target signal, counts qualified edges, then emits a one-cycle glitch_start pulse to glitch_wb.
- glitch_wb ORs glitch_start into its STATUS-write enable.
- Replaces software-timed STATUS writes, giving the glitcher a deterministic start point relative to a target event.

Parameters:
- SYNC_STAGES, 2, number of flops in the trig_in synchroniser; minimum 2.

Ports:
- clk_i  in  1  system clock; everything in this block is on this clock.
- rst_i  in  1  reset, synchronous, active-high.
- dat_i  in  8  Wishbone write data.
- adr_i  in  4 [5:2]  Wishbone register address.
- dat_o  out  8  Wishbone read data.
- stb_i  in  1  Wishbone strobe.
- we_i  in  1  Wishbone write enable.
- ack_o  out  1  Wishbone acknowledge.
- trig_in  in  1  asynchronous target trigger pin.
- glitch_rdy  in  1  glitch_wb ready flag; 1 = idle and able to start.
- glitch_start  out  1  one-cycle start pulse to glitch_wb.
- armed  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset state:
  - FSM IDLE.
  - glitch_start=0, armed=0, ack_o=0, dat_o=0x00.
  - CFG=0x00, COUNT=0x0000, MISSED=0, FIRED=0, FIRE_CNT=0x00, synchroniser flops=0.
- Wishbone:
  - ack_o <= stb_i & ~ack_o, i.e. a registered single-cycle ack one clock after strobe.
  - dat_o is registered in the same cycle as ack_o.
  - Writes take effect on the acking edge.
  - Unmapped addresses read 0x00 and are still acked; writes to them are ignored.
- Register map (new constants in glitch_defs.v):
  - TRIG_CTRL 4'h8
    - Write: bit0 ARM, bit1 ABORT, bit2 CLR. All are self-clearing commands.
    - Read: bit0 armed, bit1 MISSED, bit2 FIRED, bit3 live synchronised trig level, bits 7:4 = 0.
  - TRIG_CFG 4'h9, R/W.
    - bits1:0 EDGE: 00 rising, 01 falling, 10 both, 11 level-high.
    - bit2 AUTO_REARM.
    - bits 7:3 read 0.
  - TRIG_COUNT_0 / TRIG_COUNT_1, 4'hA / 4'hB, R/W: low and high bytes of the 16-bit edge count N.
  - TRIG_FIRE_CNT 4'hC
    - Read: number of pulses issued, 8-bit, saturates at 0xFF.
    - Write any value: clears it to 0.
- Edge detection:
  - trig_in passes through SYNC_STAGES flops, giving s.
  - prev is s delayed by one cycle.
  - Qualifying event: rising = s&~prev; falling = ~s&prev; both = s^prev; level = s.
- FSM states: IDLE, ARMED, FIRE.
  - IDLE --ARM--> ARMED.
    - On ARM: latch N into a shadow register (N=0 is treated as 1), clear the edge counter, clear MISSED and FIRED.
  - ARMED: each qualifying event increments the 16-bit edge counter.
    - Level mode ignores N and completes on the first event.
    - On the cycle the counter reaches the shadow N:
      - glitch_rdy=1: go to FIRE.
      - glitch_rdy=0: set MISSED, no pulse; then re-ARM if AUTO_REARM, else go to IDLE.
  - FIRE lasts one cycle:
    - glitch_start=1.
    - FIRED<=1; FIRE_CNT increments.
    - Next state is ARMED (counter cleared, shadow N reloaded) if AUTO_REARM, else IDLE.
- Latency: with SYNC_STAGES=2 and N=1, glitch_start is high during the cycle that begins 3 rising edges after the edge that first samples the new trig_in level.
- Boundary cases:
  - ABORT in any state: IDLE next edge, no pulse. ABORT wins over a simultaneous ARM or a count match.
  - ARM while ARMED restarts the edge counter and reloads N.
  - Writes to COUNT/CFG while ARMED do not affect the current run (shadow N). EDGE is also latched at ARM.
  - CLR clears MISSED and FIRED only.
  - rst_i mid-run: IDLE at that edge, and any pending glitch_start is dropped.
  - Edge counter stops at the match and never wraps.

Decomposition:
- Register addresses, CTRL bit positions, EDGE encodings and FSM state codes (T_IDLE, T_ARMED, T_FIRE) go in glitch_defs.v.
- One sub-module, trig_sync_edge: synchroniser plus prev flop plus edge-select mux.
  - Inputs: clk_i, rst_i, trig_in, edge_sel.
  - Outputs: level, event.

Test Plan:
1. Reset, then read all registers -> CTRL=0x00 (bit3 follows trig_in=0), CFG=0x00, COUNT_0/1=0x00, FIRE_CNT=0x00; each access acked exactly one cycle after stb_i.
2. CFG=0x00, COUNT=0x0003, ARM, three rising edges on trig_in with glitch_rdy=1 -> single glitch_start pulse 3 edges after the third edge is sampled; CTRL reads 0x04 (FIRED set, not armed); FIRE_CNT=0x01.
3. Same setup, ABORT after 2 edges, then a 3rd edge -> no pulse; CTRL=0x00.
4. CFG=0x02 (both edges), COUNT=0x0004, ARM, glitch_rdy=0 throughout 2 full trig_in periods -> no pulse; CTRL=0x02 (MISSED); CLR -> CTRL=0x00.
5. CFG=0x04 (auto re-arm, rising), COUNT=0x0001, ARM, 5 rising edges -> 5 pulses; armed stays 1; FIRE_CNT=0x05.
6. End-to-end with glitch_wb (WIDTH=4, MODE=AND): triggered pulse -> glitch_rdy drops, clk_out is gated for 4 clk_in cycles, glitch_rdy returns to 1.
